oam_dma_engine: RTL and testbench
=================================

Name: oam_dma_engine

Overview:
- Parametrised OAM DMA controller for the Game Boy video subsystem.
- A write to the DMA page register copies OAM_SIZE bytes from source page {page, 00h..} into sprite attribute memory, at one byte per CYCLES_PER_BYTE clocks.
- CPU access to OAM is blocked while the copy runs.
- Sits between the data-bus peripheral decode and the whizgraphics OAM write port.

Parameters:
- ADDR_W, 16, system bus address width.
- DATA_W, 8, data width.
- OAM_SIZE, 160, bytes per transfer (1..256).
- OAM_ADDR_W, 8, OAM index width.
- CYCLES_PER_BYTE, 4, clocks per byte period (>=2).
- START_DELAY, 1, idle byte periods between the register write and the first read (>=0).

Ports:
- clk  in  1  system clock, all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- reg_we  in  1  DMA register write strobe (address decoded externally).
- reg_wdata  in  ADDR_W-8  source page, the upper address bits.
- reg_rdata  out  ADDR_W-8  last written page.
- src_rd  out  1  source read strobe.
- src_addr  out  ADDR_W  source address.
- src_data  in  DATA_W  source read data, valid exactly 1 clock after src_rd.
- oam_we  out  1  OAM write strobe.
- oam_addr  out  OAM_ADDR_W  OAM index.
- oam_wdata  out  DATA_W  OAM write data.
- busy  out  1  transfer in progress.
- cpu_block  out  1  OAM CPU access lockout; equals busy.
- done  out  1  one-clock completion pulse.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - All outputs 0: reg_rdata, src_rd, src_addr, oam_we, oam_addr, oam_wdata, busy, done.
  - Period counter and byte index cleared.
- FSM states: IDLE, DELAY, XFER. Internal counters:
  - cyc, 0..CYCLES_PER_BYTE-1.
  - idx, 0..OAM_SIZE-1.
  - dly, 0..START_DELAY.
- Starting a transfer:
  - reg_we=1 in any state latches reg_wdata into the page register (visible on reg_rdata the next clock).
  - Sets cyc=0, idx=0, dly=0.
  - Enters DELAY if START_DELAY>0, otherwise XFER.
  - busy=1 from the next clock.
- DELAY: cyc counts each clock. On the cyc wrap, dly increments. When dly reaches START_DELAY, go to XFER with cyc=0.
- XFER, within each byte period:
  - cyc=0: src_rd=1, src_addr={page, idx zero-extended to 8 bits}.
  - cyc=1: oam_we=1, oam_addr=idx, oam_wdata=src_data.
  - cyc>=2: no strobes.
  - Strobes are single-clock and registered outputs. Outside these cycles, src_rd=0 and oam_we=0, and the address/data outputs hold their values.
- End of byte period (cyc=CYCLES_PER_BYTE-1):
  - If idx<OAM_SIZE-1: idx increments, cyc wraps to 0.
  - If idx=OAM_SIZE-1: go to IDLE, busy=0, done=1 for one clock.
- Latency and duration:
  - busy is high for exactly (START_DELAY+OAM_SIZE)*CYCLES_PER_BYTE clocks.
  - The first src_rd occurs START_DELAY*CYCLES_PER_BYTE+1 clocks after the reg_we clock.
- Restart mid-transfer: reg_we while busy discards the current transfer immediately.
  - A pending cyc=1 write of the old transfer is suppressed.
  - No done pulse for the aborted transfer.
  - The restart behaves exactly like a start from IDLE.
- Simultaneous reg_we and the final cyc: the restart wins and done is not asserted.
- Asynchronous reset mid-transfer aborts everything. No further strobes occur until the next reg_we after rst_n deasserts.
- Source addresses never cross the page: idx<256 is guaranteed by the OAM_SIZE bound.

Test Plan:
- Reset: hold rst_n=0 mid-transfer -> all outputs 0 within the same clock (asynchronous). After release, no src_rd or oam_we occurs until reg_we.
- Basic copy, defaults: fill source C000h..C09Fh with random bytes, write page C0h -> reg_rdata=C0h, busy high 644 clocks, 160 oam_we pulses at oam_addr 0..159 with data matching source, done pulse once. Read back through the OAM data bus: 160 of 160 match.
- Timing: write page 80h -> first src_rd at clock 5 after reg_we with src_addr=8000h, first oam_we at clock 6. Consecutive oam_we pulses are 4 clocks apart.
- Restart: write C0h, then at byte 50 write D0h -> no write to oam_addr 50 from the C0h transfer after the abort. Next oam_we is oam_addr 0 with D000h data, total busy 644 clocks from the second write, one done pulse.
- Parametrised instance (OAM_SIZE=40, CYCLES_PER_BYTE=2, START_DELAY=0): write 12h -> first src_rd on the next clock with src_addr=1200h, busy 80 clocks, 40 writes.
- Boundary: reg_we coincident with the final cyc of byte 159 -> done stays 0 and a new transfer starts from idx 0.

Source files
------------

// File: rtl/oam_dma_engine.sv
// oam_dma_engine: a page-register write copies OAM_SIZE source bytes into OAM, one byte per CYCLES_PER_BYTE clocks.
// The CPU is locked out of OAM while the copy runs.
module oam_dma_engine #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int OAM_SIZE = 160,
  parameter int OAM_ADDR_W = 8,
  parameter int CYCLES_PER_BYTE = 4,
  parameter int START_DELAY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reg_we,
  input  logic [ADDR_W-9:0]     reg_wdata,
  output logic [ADDR_W-9:0]     reg_rdata,
  output logic                  src_rd,
  output logic [ADDR_W-1:0]     src_addr,
  input  logic [DATA_W-1:0]     src_data,
  output logic                  oam_we,
  output logic [OAM_ADDR_W-1:0] oam_addr,
  output logic [DATA_W-1:0]     oam_wdata,
  output logic                  busy,
  output logic                  cpu_block,
  output logic                  done
);
  localparam int CW = $clog2(CYCLES_PER_BYTE);
  localparam int DW = START_DELAY > 0 ? $clog2(START_DELAY + 1) : 1;
  typedef enum logic [1:0] {IDLE, DELAY, XFER} state_t;
  state_t state, state_n;
  logic [CW-1:0] cyc, cyc_n;
  logic [7:0] idx, idx_n;
  logic [DW-1:0] dly, dly_n;
  logic rd_n, we_n, done_n, cyc_last;
  assign cyc_last = cyc == CW'(CYCLES_PER_BYTE - 1);
  always_comb begin
    state_n = state;
    cyc_n = cyc;
    idx_n = idx;
    dly_n = dly;
    done_n = 1'b0;
    // a register write in the same clock cancels any strobe of the old transfer
    rd_n = !reg_we && state == XFER && cyc == '0;
    we_n = !reg_we && state == XFER && cyc == CW'(1);
    if (reg_we) begin
      state_n = START_DELAY > 0 ? DELAY : XFER;
      cyc_n = '0;
      idx_n = '0;
      dly_n = '0;
    end else if (state != IDLE) begin
      cyc_n = cyc_last ? '0 : cyc + CW'(1);
      if (state == DELAY && cyc_last) begin
        dly_n = dly + DW'(1);
        state_n = dly_n == DW'(START_DELAY) ? XFER : DELAY;
      end else if (state == XFER && cyc_last) begin
        idx_n = idx == 8'(OAM_SIZE - 1) ? idx : idx + 8'd1;
        state_n = idx == 8'(OAM_SIZE - 1) ? IDLE : XFER;
        done_n = idx == 8'(OAM_SIZE - 1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cyc <= '0;
      idx <= '0;
      dly <= '0;
      reg_rdata <= '0;
      src_rd <= 1'b0;
      src_addr <= '0;
      oam_we <= 1'b0;
      oam_addr <= '0;
      oam_wdata <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      cyc <= cyc_n;
      idx <= idx_n;
      dly <= dly_n;
      src_rd <= rd_n;
      oam_we <= we_n;
      done <= done_n;
      if (reg_we) reg_rdata <= reg_wdata;
      if (rd_n) src_addr <= {reg_rdata, idx};
      if (we_n) begin
        oam_addr <= OAM_ADDR_W'(idx);
        oam_wdata <= src_data;
      end
    end
  end
  assign busy = state != IDLE;
  assign cpu_block = busy;
endmodule

// File: tb/tb_oam_dma_engine.sv
// tb_oam_dma_engine: vector table plus a clock-count reference model checking a default
// and a small fast engine side by side every cycle.
module tb_oam_dma_engine;
  localparam int NS [2] = '{160, 40};
  localparam int CS [2] = '{4, 2};
  localparam int DS [2] = '{1, 0};
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic we [2];
  logic [7:0] wd [2];
  logic [7:0] reg_rdata [2];
  logic src_rd [2], oam_we [2], busy [2], cpu_block [2], done [2];
  logic [15:0] src_addr [2];
  logic [7:0] src_data [2], oam_addr [2], oam_wdata [2];
  bit [7:0] mem [65536];
  bit [7:0] oam_sh [2][256];
  int vectors = 0, miscompares = 0;
  bit mon_en = 1'b0;
  bit m_act [2];
  int m_t [2];
  bit [7:0] m_page [2];
  bit [15:0] h_sa [2];
  bit [7:0] h_oa [2], h_od [2];
  typedef struct {
    int g;
    bit [7:0] page;
    int wait_k;
    bit [7:0] page2;
    int pre_writes;
    int exp_busy;
    int exp_writes;
  } vec_t;
  vec_t tbl [9];

  always #5 clk = ~clk;
  assign src_data[0] = mem[src_addr[0]];
  assign src_data[1] = mem[src_addr[1]];

  oam_dma_engine dut0 (
    .clk(clk), .rst_n(rst_n), .reg_we(we[0]), .reg_wdata(wd[0]), .reg_rdata(reg_rdata[0]),
    .src_rd(src_rd[0]), .src_addr(src_addr[0]), .src_data(src_data[0]),
    .oam_we(oam_we[0]), .oam_addr(oam_addr[0]), .oam_wdata(oam_wdata[0]),
    .busy(busy[0]), .cpu_block(cpu_block[0]), .done(done[0])
  );
  oam_dma_engine #(.OAM_SIZE(40), .CYCLES_PER_BYTE(2), .START_DELAY(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .reg_we(we[1]), .reg_wdata(wd[1]), .reg_rdata(reg_rdata[1]),
    .src_rd(src_rd[1]), .src_addr(src_addr[1]), .src_data(src_data[1]),
    .oam_we(oam_we[1]), .oam_addr(oam_addr[1]), .oam_wdata(oam_wdata[1]),
    .busy(busy[1]), .cpu_block(cpu_block[1]), .done(done[1])
  );

  always @(posedge clk) begin
    if (oam_we[0]) oam_sh[0][oam_addr[0]] <= oam_wdata[0];
    if (oam_we[1]) oam_sh[1][oam_addr[1]] <= oam_wdata[1];
  end

  // reference: m_t counts clocks since the last page write; everything else is arithmetic on it
  always @(posedge clk or negedge rst_n)
    for (int g = 0; g < 2; g++)
      if (!rst_n) begin
        m_act[g] <= 1'b0;
        m_t[g] <= 0;
        m_page[g] <= 8'h00;
      end else if (we[g]) begin
        m_act[g] <= 1'b1;
        m_t[g] <= 0;
        m_page[g] <= wd[g];
      end else if (m_act[g]) begin
        m_act[g] <= m_t[g] < (DS[g] + NS[g]) * CS[g];
        m_t[g] <= m_t[g] + 1;
      end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs(int g);
    return 64'({reg_rdata[g], src_rd[g], src_addr[g], oam_we[g], oam_addr[g], oam_wdata[g],
                busy[g], cpu_block[g], done[g]});
  endfunction

  always @(negedge clk) if (mon_en) for (int g = 0; g < 2; g++) begin
    int base, tot, r, o;
    bit e_rd, e_we, e_busy, e_done;
    base = DS[g] * CS[g];
    tot = (DS[g] + NS[g]) * CS[g];
    r = m_t[g] - base - 1;
    o = m_t[g] - base - 2;
    e_busy = m_act[g] && m_t[g] < tot;
    e_done = m_act[g] && m_t[g] == tot;
    e_rd = m_act[g] && r >= 0 && r % CS[g] == 0 && r / CS[g] < NS[g];
    e_we = m_act[g] && o >= 0 && o % CS[g] == 0 && o / CS[g] < NS[g];
    if (!rst_n) begin
      h_sa[g] = 16'h0000;
      h_oa[g] = 8'h00;
      h_od[g] = 8'h00;
    end
    if (e_rd) h_sa[g] = {m_page[g], 8'(r / CS[g])};
    if (e_we) begin
      h_oa[g] = 8'(o / CS[g]);
      h_od[g] = mem[{m_page[g], 8'(o / CS[g])}];
    end
    check($sformatf("dut%0d cycle t=%0d", g, m_t[g]), outs(g),
          64'({m_page[g], e_rd, h_sa[g], e_we, h_oa[g], h_od[g], e_busy, e_busy, e_done}));
  end

  task automatic pulse(int g, bit [7:0] p);
    we[g] = 1'b1;
    wd[g] = p;
    @(negedge clk);
    we[g] = 1'b0;
  endtask

  initial begin
    int b, n, w, d, bz, m, g;
    bit [7:0] fp;
    we[0] = 1'b0;
    we[1] = 1'b0;
    wd[0] = 8'h00;
    wd[1] = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    tbl[0] = '{0, 8'hC0, -1, 8'h00, 0, 644, 160};
    tbl[1] = '{0, 8'h80, -1, 8'h00, 0, 644, 160};
    tbl[2] = '{0, 8'hC0, 205, 8'hD0, 50, 644, 160};
    tbl[3] = '{0, 8'h55, 643, 8'h77, 160, 644, 160};
    tbl[4] = '{1, 8'h12, -1, 8'h00, 0, 80, 40};
    tbl[5] = '{1, 8'h34, 79, 8'h56, 39, 80, 40};
    b = $urandom_range(1, 39);
    tbl[6] = '{1, 8'($urandom), 1 + 2 * b, 8'($urandom), b, 80, 40};
    b = $urandom_range(1, 159);
    tbl[7] = '{0, 8'($urandom), 5 + 4 * b, 8'($urandom), b, 644, 160};
    tbl[8] = '{1, 8'($urandom), -1, 8'h00, 0, 80, 40};
    #1 rst_n = 1'b0;
    #1 check("reset dut0", outs(0), 64'd0);
    check("reset dut1", outs(1), 64'd0);
    mon_en = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    pulse(0, 8'h80);
    n = 0;
    while (!src_rd[0] && n < 20) begin @(negedge clk); n++; end
    check("first src_rd clock", 64'(n), 64'd5);
    check("first src_addr", 64'(src_addr[0]), 64'h8000);
    while (!oam_we[0] && n < 20) begin @(negedge clk); n++; end
    check("first oam_we clock", 64'(n), 64'd6);
    check("first oam_wdata", 64'(oam_wdata[0]), 64'(mem[16'h8000]));
    @(negedge clk);
    n = 1;
    while (!oam_we[0] && n < 20) begin @(negedge clk); n++; end
    check("oam_we spacing", 64'(n), 64'd4);
    for (int k = 0; k < 800 && busy[0]; k++) @(negedge clk);
    check("dut0 idle", 64'(busy[0]), 64'd0);
    pulse(1, 8'h12);
    n = 0;
    while (!src_rd[1] && n < 20) begin @(negedge clk); n++; end
    check("dut1 first src_rd clock", 64'(n), 64'd1);
    check("dut1 first src_addr", 64'(src_addr[1]), 64'h1200);
    for (int k = 0; k < 200 && busy[1]; k++) @(negedge clk);
    check("dut1 idle", 64'(busy[1]), 64'd0);
    foreach (tbl[i]) begin
      g = tbl[i].g;
      fp = tbl[i].page;
      pulse(g, fp);
      if (tbl[i].wait_k >= 0) begin
        w = 0;
        d = 0;
        for (int k = 0; k < tbl[i].wait_k; k++) begin
          if (oam_we[g]) w++;
          if (done[g]) d++;
          @(negedge clk);
        end
        check($sformatf("v%0d writes before restart", i), 64'(w), 64'(tbl[i].pre_writes));
        check($sformatf("v%0d done before restart", i), 64'(d), 64'd0);
        fp = tbl[i].page2;
        pulse(g, fp);
      end
      w = 0;
      d = 0;
      bz = 0;
      for (int k = 0; k < tbl[i].exp_busy + 16; k++) begin
        if (busy[g]) bz++;
        if (oam_we[g]) w++;
        if (done[g]) d++;
        @(negedge clk);
      end
      check($sformatf("v%0d busy clocks", i), 64'(bz), 64'(tbl[i].exp_busy));
      check($sformatf("v%0d oam writes", i), 64'(w), 64'(tbl[i].exp_writes));
      check($sformatf("v%0d done pulses", i), 64'(d), 64'd1);
      check($sformatf("v%0d reg_rdata", i), 64'(reg_rdata[g]), 64'(fp));
      m = 0;
      for (int k = 0; k < NS[g]; k++) if (oam_sh[g][k] == mem[{fp, 8'(k)}]) m++;
      check($sformatf("v%0d oam readback", i), 64'(m), 64'(NS[g]));
    end
    pulse(0, 8'hA0);
    pulse(1, 8'hB0);
    repeat (30) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async reset dut0", outs(0), 64'd0);
    check("async reset dut1", outs(1), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (src_rd[0] || oam_we[0] || src_rd[1] || oam_we[1]) n++;
    end
    check("strobes after reset", 64'(n), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
